direct_mapped: RTL and testbench

- Direct-mapped, write-back, write-allocate cache with 32-bit words, placed between a requesting device and a word-wide external RAM.
- Byte address fields: [1:0] byte, [WORD_OFFSET_WIDTH+1:2] word-in-line, next INDEX_WIDTH bits index, remaining upper bits tag.
- Read hits complete in one cycle and can be pipelined back to back.
- Misses write back the dirty victim line word by word, then fetch the new line word by word.

---
 rtl/direct_mapped.sv | 231 +++++++++++++++++++++++
 tb/tb_direct_mapped.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/direct_mapped.sv
// Direct-mapped, write-back, write-allocate cache for 32-bit words in front of a word-wide RAM.
// Hits answer in one cycle; misses write back a dirty victim line, then fill the new line.
module direct_mapped #(
    parameter int unsigned ADDRESS_WIDTH     = 16,
    parameter int unsigned INDEX_WIDTH       = 3,
    parameter int unsigned WORD_OFFSET_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cache_address,
    input  logic                     cache_rd,
    input  logic                     cache_wr,
    input  logic [3:0]               cache_byte_enable,
    input  logic [31:0]              cache_data_wr,
    output logic [31:0]              cache_data_out,
    output logic                     cache_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [31:0]              ram_data_wr,
    input  logic [31:0]              ram_data_rd,
    input  logic                     ram_data_valid
);

    localparam int unsigned LINES      = 1 << INDEX_WIDTH;
    localparam int unsigned SLOT_WIDTH = INDEX_WIDTH + WORD_OFFSET_WIDTH;
    localparam int unsigned TAG_WIDTH  = ADDRESS_WIDTH - SLOT_WIDTH - 2;

    typedef enum logic [2:0] {
        StIdle, StWbReq, StWbWait, StFillReq, StFillWait, StComplete
    } state_e;

    state_e                         state_q, state_d;
    logic [WORD_OFFSET_WIDTH-1:0]   word_q, word_d;
    logic [ADDRESS_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic                           req_wr_q, req_wr_d;
    logic [3:0]                     req_be_q, req_be_d;
    logic [31:0]                    req_data_q, req_data_d;
    logic [LINES-1:0]               valid_q, valid_d, dirty_q, dirty_d;
    logic                           ready_q, ready_d;
    logic [31:0]                    data_out_q, data_out_d;
    logic                           ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
    logic [ADDRESS_WIDTH-1:0]       ram_addr_q, ram_addr_d;
    logic [31:0]                    ram_wdata_q, ram_wdata_d;

    logic [31:0]                    data_mem [1 << SLOT_WIDTH];
    logic [TAG_WIDTH-1:0]           tag_mem  [LINES];
    logic                           mem_we, tag_we;
    logic [SLOT_WIDTH-1:0]          mem_slot;
    logic [31:0]                    mem_wdata;

    logic [WORD_OFFSET_WIDTH-1:0]   in_word, req_word;
    logic [INDEX_WIDTH-1:0]         in_index, req_index;
    logic [TAG_WIDTH-1:0]           in_tag, req_tag;
    logic                           in_hit;
    logic                           unused_byte_bits;

    assign in_word   = cache_address[WORD_OFFSET_WIDTH+1:2];
    assign in_index  = cache_address[SLOT_WIDTH+1:WORD_OFFSET_WIDTH+2];
    assign in_tag    = cache_address[ADDRESS_WIDTH-1:SLOT_WIDTH+2];
    assign req_word  = req_addr_q[WORD_OFFSET_WIDTH+1:2];
    assign req_index = req_addr_q[SLOT_WIDTH+1:WORD_OFFSET_WIDTH+2];
    assign req_tag   = req_addr_q[ADDRESS_WIDTH-1:SLOT_WIDTH+2];
    assign in_hit    = valid_q[in_index] && (tag_mem[in_index] == in_tag);
    assign unused_byte_bits = ^{cache_address[1:0], req_addr_q[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        merge_bytes = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merge_bytes[8*i +: 8] = new_word[8*i +: 8];
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        req_addr_d  = req_addr_q;
        req_wr_d    = req_wr_q;
        req_be_d    = req_be_q;
        req_data_d  = req_data_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        ready_d     = 1'b0;
        data_out_d  = data_out_q;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        mem_we      = 1'b0;
        mem_slot    = {req_index, word_q};
        mem_wdata   = ram_data_rd;
        tag_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cache_rd || cache_wr) begin
                    req_addr_d = cache_address;
                    req_wr_d   = cache_wr;
                    req_be_d   = cache_byte_enable;
                    req_data_d = cache_data_wr;
                    if (in_hit) begin
                        ready_d  = 1'b1;
                        mem_slot = {in_index, in_word};
                        if (cache_wr) begin
                            mem_wdata = merge_bytes(data_mem[{in_index, in_word}], cache_data_wr,
                                                    cache_byte_enable);
                            mem_we             = 1'b1;
                            dirty_d[in_index]  = 1'b1;
                            data_out_d         = mem_wdata;
                        end else begin
                            data_out_d = data_mem[{in_index, in_word}];
                        end
                    end else begin
                        word_d = '0;
                        if (valid_q[in_index] && dirty_q[in_index]) begin
                            ram_wr_d    = 1'b1;
                            ram_addr_d  = {tag_mem[in_index], in_index,
                                           {WORD_OFFSET_WIDTH{1'b0}}, 2'b00};
                            ram_wdata_d = data_mem[{in_index, {WORD_OFFSET_WIDTH{1'b0}}}];
                            state_d     = StWbReq;
                        end else begin
                            ram_rd_d   = 1'b1;
                            ram_addr_d = {in_tag, in_index, {WORD_OFFSET_WIDTH{1'b0}}, 2'b00};
                            state_d    = StFillReq;
                        end
                    end
                end
            end
            StWbReq, StWbWait: begin
                if (ram_data_valid) begin
                    // The last write-back ack launches the first fill read on the same edge.
                    if (&word_q) begin
                        word_d     = '0;
                        ram_rd_d   = 1'b1;
                        ram_addr_d = {req_tag, req_index, {WORD_OFFSET_WIDTH{1'b0}}, 2'b00};
                        state_d    = StFillReq;
                    end else begin
                        word_d      = word_q + 1'b1;
                        ram_wr_d    = 1'b1;
                        ram_addr_d  = {tag_mem[req_index], req_index, word_d, 2'b00};
                        ram_wdata_d = data_mem[{req_index, word_d}];
                        state_d     = StWbReq;
                    end
                end else if (state_q == StWbReq) begin
                    state_d = StWbWait;
                end
            end
            StFillReq, StFillWait: begin
                if (ram_data_valid) begin
                    mem_we = 1'b1;
                    if (&word_q) begin
                        state_d = StComplete;
                    end else begin
                        word_d     = word_q + 1'b1;
                        ram_rd_d   = 1'b1;
                        ram_addr_d = {req_tag, req_index, word_d, 2'b00};
                        state_d    = StFillReq;
                    end
                end else if (state_q == StFillReq) begin
                    state_d = StFillWait;
                end
            end
            StComplete: begin
                tag_we             = 1'b1;
                valid_d[req_index] = 1'b1;
                dirty_d[req_index] = req_wr_q;
                mem_slot           = {req_index, req_word};
                ready_d            = 1'b1;
                if (req_wr_q) begin
                    mem_wdata  = merge_bytes(data_mem[{req_index, req_word}], req_data_q, req_be_q);
                    mem_we     = 1'b1;
                    data_out_d = mem_wdata;
                end else begin
                    data_out_d = data_mem[{req_index, req_word}];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_be_q    <= '0;
            req_data_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            ready_q     <= 1'b0;
            data_out_q  <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            req_addr_q  <= req_addr_d;
            req_wr_q    <= req_wr_d;
            req_be_q    <= req_be_d;
            req_data_q  <= req_data_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            ready_q     <= ready_d;
            data_out_q  <= data_out_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Storage arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (mem_we) data_mem[mem_slot] <= mem_wdata;
        if (tag_we) tag_mem[req_index] <= req_tag;
    end

    assign cache_ready    = ready_q;
    assign cache_data_out = data_out_q;
    assign ram_rd         = ram_rd_q;
    assign ram_wr         = ram_wr_q;
    assign ram_address    = ram_addr_q;
    assign ram_data_wr    = ram_wdata_q;

endmodule

// File: tb/tb_direct_mapped.sv
// Directed bench for direct_mapped: a 1-cycle-ack RAM model, a vector table of cache requests
// and hand-written sequences for back-to-back hits, idle quiet time and reset during a fill.
module tb_direct_mapped;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cache_address;
    logic        cache_rd, cache_wr;
    logic [3:0]  cache_byte_enable;
    logic [31:0] cache_data_wr, cache_data_out;
    logic        cache_ready;
    logic [15:0] ram_address;
    logic        ram_rd, ram_wr;
    logic [31:0] ram_data_wr, ram_data_rd;
    logic        ram_data_valid;

    int checks = 0;
    int failures = 0;
    int proto_err = 0;

    always #5 clk = ~clk;

    direct_mapped #(
        .ADDRESS_WIDTH(16),
        .INDEX_WIDTH(3),
        .WORD_OFFSET_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cache_address(cache_address),
        .cache_rd(cache_rd),
        .cache_wr(cache_wr),
        .cache_byte_enable(cache_byte_enable),
        .cache_data_wr(cache_data_wr),
        .cache_data_out(cache_data_out),
        .cache_ready(cache_ready),
        .ram_address(ram_address),
        .ram_rd(ram_rd),
        .ram_wr(ram_wr),
        .ram_data_wr(ram_data_wr),
        .ram_data_rd(ram_data_rd),
        .ram_data_valid(ram_data_valid)
    );

    // RAM model: unwritten word n reads as byte n[7:0] replicated; ack one cycle after strobe.
    logic [31:0] ram_mem [16384];
    logic        ram_written [16384];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    logic [31:0] wd_log[$];
    logic        prev_rd = 1'b0, prev_wr = 1'b0;

    function automatic logic [31:0] ram_word(input logic [13:0] n);
        logic [7:0] b;
        b = n[7:0];
        return ram_written[n] ? ram_mem[n] : {b, b, b, b};
    endfunction

    always @(posedge clk) begin
        ram_data_valid <= 1'b0;
        if (ram_rd) begin
            rd_log.push_back(ram_address);
            ram_data_rd    <= ram_word(ram_address[15:2]);
            ram_data_valid <= 1'b1;
        end
        if (ram_wr) begin
            wr_log.push_back(ram_address);
            wd_log.push_back(ram_data_wr);
            ram_mem[ram_address[15:2]]     <= ram_data_wr;
            ram_written[ram_address[15:2]] <= 1'b1;
            ram_data_valid                 <= 1'b1;
        end
        if (ram_rd && ram_wr) proto_err = proto_err + 1;
        if ((ram_rd && prev_rd) || (ram_wr && prev_wr)) proto_err = proto_err + 1;
        if ((ram_rd || ram_wr) && ram_address[1:0] != 2'b00) proto_err = proto_err + 1;
        prev_rd <= ram_rd;
        prev_wr <= ram_wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue a one-cycle request; latency counts edges from the accepting edge to ready (0 = none).
    task automatic do_req(input logic [15:0] a, input logic wr, input logic [3:0] be,
                          input logic [31:0] d, output int lat, output logic [31:0] q);
        @(negedge clk);
        cache_address     = a;
        cache_rd          = !wr;
        cache_wr          = wr;
        cache_byte_enable = be;
        cache_data_wr     = d;
        @(negedge clk);
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        lat = 0;
        q   = '0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (cache_ready) begin
                lat = k + 1;
                q   = cache_data_out;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [15:0] exp_wb_base;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat;
        int          rd_start, wr_start;
        logic [31:0] q;
        logic [15:0] base;

        vecs[0] = '{16'h0020, 1'b0, 4'hF, 32'h0,        32'h08080808, 10, 4, 0, 16'h0000};
        vecs[1] = '{16'hD030, 1'b1, 4'hF, 32'h00001234, 32'h00001234, 10, 4, 0, 16'h0000};
        vecs[2] = '{16'hA840, 1'b0, 4'hF, 32'h0,        32'h10101010, 10, 4, 0, 16'h0000};
        vecs[3] = '{16'hD034, 1'b1, 4'hF, 32'h00005678, 32'h00005678, 1,  0, 0, 16'h0000};
        vecs[4] = '{16'h3D30, 1'b1, 4'h1, 32'h00000008, 32'h4C4C4C08, 18, 4, 4, 16'hD030};
        vecs[5] = '{16'h5630, 1'b0, 4'hF, 32'h0,        32'h8C8C8C8C, 18, 4, 4, 16'h3D30};

        for (int n = 0; n < 16384; n++) ram_written[n] = 1'b0;
        rst = 1'b0;
        cache_address = '0;
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        cache_byte_enable = '0;
        cache_data_wr = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, cache_ready}, 32'h0);
        chk("reset_ram_rd", {31'b0, ram_rd}, 32'h0);
        chk("reset_ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("reset_data_out", cache_data_out, 32'h0);
        chk("reset_ram_address", {16'h0, ram_address}, 32'h0);
        chk("reset_ram_data_wr", ram_data_wr, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                // Two back-to-back read hits, second request issued while the first answers.
                rd_start = rd_log.size();
                wr_start = wr_log.size();
                @(negedge clk);
                cache_address = 16'h002C;
                cache_rd      = 1'b1;
                @(negedge clk);
                cache_address = 16'hA844;
                chk("pipe_ready0", {31'b0, cache_ready}, 32'h1);
                chk("pipe_data0", cache_data_out, 32'h0B0B0B0B);
                @(negedge clk);
                cache_rd = 1'b0;
                chk("pipe_ready1", {31'b0, cache_ready}, 32'h1);
                chk("pipe_data1", cache_data_out, 32'h11111111);
                @(negedge clk);
                chk("pipe_ready_drop", {31'b0, cache_ready}, 32'h0);
                chk("pipe_no_strobes", rd_log.size() + wr_log.size() - rd_start - wr_start, 0);
            end
            rd_start = rd_log.size();
            wr_start = wr_log.size();
            do_req(vecs[i].addr, vecs[i].wr, vecs[i].be, vecs[i].wdata, lat, q);
            chk($sformatf("v%0d_data", i), q, vecs[i].exp_data);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_nrd", i), rd_log.size() - rd_start, vecs[i].exp_nrd);
            chk($sformatf("v%0d_nwr", i), wr_log.size() - wr_start, vecs[i].exp_nwr);
            base = vecs[i].addr & 16'hFFF0;
            for (int w = 0; w < vecs[i].exp_nrd && rd_start + w < rd_log.size(); w++)
                chk($sformatf("v%0d_rd_addr%0d", i, w), {16'h0, rd_log[rd_start+w]},
                    {16'h0, base + 16'(4*w)});
            for (int w = 0; w < vecs[i].exp_nwr && wr_start + w < wr_log.size(); w++)
                chk($sformatf("v%0d_wb_addr%0d", i, w), {16'h0, wr_log[wr_start+w]},
                    {16'h0, vecs[i].exp_wb_base + 16'(4*w)});
        end

        chk("ram_D030", ram_word(14'(16'hD030 >> 2)), 32'h00001234);
        chk("ram_D034", ram_word(14'(16'hD034 >> 2)), 32'h00005678);
        chk("ram_D038", ram_word(14'(16'hD038 >> 2)), 32'h0E0E0E0E);
        chk("ram_D03C", ram_word(14'(16'hD03C >> 2)), 32'h0F0F0F0F);
        chk("ram_3D30", ram_word(14'(16'h3D30 >> 2)), 32'h4C4C4C08);

        rd_start = rd_log.size();
        wr_start = wr_log.size();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("idle_ready%0d", k), {31'b0, cache_ready}, 32'h0);
        end
        chk("idle_no_strobes", rd_log.size() + wr_log.size() - rd_start - wr_start, 0);

        // Reset while the first fill read is on the bus.
        @(negedge clk);
        cache_address = 16'h0060;
        cache_rd      = 1'b1;
        @(negedge clk);
        cache_rd = 1'b0;
        chk("fill_strobe_up", {31'b0, ram_rd}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_ram_rd", {31'b0, ram_rd}, 32'h0);
        chk("abort_ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("abort_ready", {31'b0, cache_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_start = rd_log.size();
        do_req(16'h0020, 1'b0, 4'hF, 32'h0, lat, q);
        chk("post_reset_data", q, 32'h08080808);
        chk("post_reset_latency", lat, 10);
        chk("post_reset_nrd", rd_log.size() - rd_start, 4);

        @(negedge clk);
        chk("protocol_errors", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
